// File: rtl/split_constraint_pipe.sv
// -----------------------------------------------------------------------------
// split_constraint_pipe
//
// Streaming checker for split constraint candidates. Each accepted candidate
// carries a narrow operand A (divide constraint), a wide operand B (add/shift
// constraint) and a 3-bit enable mask. Three constraints are evaluated:
//   C0 = |(((-a) mod 2^A_W) / DIV)
//   C1 = (a != 0) && (b != 0)
//   C2 = |(((zext(b) + OFFSET) mod 2^CALC_W) >> SHIFT)
// and the result is the AND of the enabled ones (empty mask passes).
// Two register stages with valid/ready backpressure, one candidate per cycle.
//
// Optional feature (macro SPLIT_CONSTRAINT_STATS_EN): saturating pass/fail
// counters of delivered results, with a synchronous clear.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   candidate handshake (in_ready is combinational)
//   in_a [A_W], in_b [B_W], in_mask [3]   candidate and constraint enables
//   out_valid / out_ready result handshake
//   out_x                 AND of enabled constraints
//   out_flags [3]         raw {C2, C1, C0}
//   stats_clr, pass_cnt [CNT_W], fail_cnt [CNT_W]   (macro builds only)
// -----------------------------------------------------------------------------
module split_constraint_pipe #(
    parameter int          A_W    = 4,
    parameter int          B_W    = 12,
    parameter int          CALC_W = 16,
    parameter int          DIV    = 5,
    parameter logic [31:0] OFFSET = 32'h0000_0BA9,
    parameter int          SHIFT  = 4,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic [2:0]       in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_x,
    output logic [2:0]       out_flags
`ifdef SPLIT_CONSTRAINT_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`endif
);

    // Configuration sanity, resolved at elaboration.
    if (CALC_W < B_W || DIV == 0 || SHIFT >= CALC_W || CNT_W < 1 || A_W > 32) begin : g_bad_cfg
        $error("split_constraint_pipe: illegal parameter set");
    end

    function automatic logic c0_eval(input logic [A_W-1:0] a);
        logic [A_W-1:0] neg;
        neg = -a;
        return ((32'(neg) / 32'(DIV)) != 32'd0);
    endfunction

    function automatic logic c1_eval(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        return (|a) && (|b);
    endfunction

    function automatic logic c2_eval(input logic [B_W-1:0] b);
        logic [CALC_W-1:0] sum;
        sum = CALC_W'(b) + CALC_W'(OFFSET);
        return |(sum >> SHIFT);
    endfunction

    function automatic logic masked_and(input logic [2:0] mask, input logic [2:0] flags);
        return &(~mask | flags);
    endfunction

    // Reset is asserted asynchronously but released on a clock edge, so the
    // pipeline never leaves reset on an arbitrary phase of rst_n.
    logic rst_meta_n;
    logic rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    logic       vld_p1;
    logic [2:0] flags_p1;
    logic [2:0] mask_p1;
    logic       vld_p2;
    logic [2:0] flags_p2;
    logic       x_p2;
    logic       s1_adv;
    logic       s2_adv;

    assign s2_adv = !vld_p2 || out_ready;
    assign s1_adv = !vld_p1 || s2_adv;
    // Held low while the internal reset is still released-pending, so no
    // candidate is accepted into a pipeline that is still being cleared.
    assign in_ready = s1_adv && rst_sync_n;

    // ---- stage 1: constraint evaluation ----
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            flags_p1 <= {c2_eval(in_b), c1_eval(in_a, in_b), c0_eval(in_a)};
            mask_p1  <= in_mask;
        end
    end

    // ---- stage 2: masked AND and output register ----
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vld_p2   <= 1'b0;
            flags_p2 <= 3'b000;
            x_p2     <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                flags_p2 <= flags_p1;
                x_p2     <= masked_and(mask_p1, flags_p1);
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_x     = x_p2;
    assign out_flags = flags_p2;

`ifdef SPLIT_CONSTRAINT_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // ---- statistics on delivered results ----
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (stats_clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (vld_p2 && out_ready) begin
            if (x_p2) begin
                pass_cnt <= sat_inc(pass_cnt);
            end else begin
                fail_cnt <= sat_inc(fail_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_split_constraint_pipe.sv
module tb_split_constraint_pipe;
    localparam int          A_W    = 4;
    localparam int          B_W    = 16;
    localparam int          CALC_W = 16;
    localparam int          DIV    = 5;
    localparam logic [31:0] OFFSET = 32'h0000_0BA9;
    localparam int          SHIFT  = 4;
`ifdef SPLIT_CONSTRAINT_STATS_EN
    localparam int          CNT_W  = 2;
`else
    localparam int          CNT_W  = 16;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic [2:0]       in_mask;
    logic             out_valid;
    logic             out_ready;
    logic             out_x;
    logic [2:0]       out_flags;
`ifdef SPLIT_CONSTRAINT_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
`endif

    split_constraint_pipe #(
        .A_W(A_W), .B_W(B_W), .CALC_W(CALC_W), .DIV(DIV),
        .OFFSET(OFFSET), .SHIFT(SHIFT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_flags(out_flags)
`ifdef SPLIT_CONSTRAINT_STATS_EN
        , .stats_clr(stats_clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];      // {flags[2:0], x} per accepted candidate
    logic [3:0]  pend_exp;
    logic        last_acc;
    logic        hold = 1'b0;
    int          n_dlv = 0;
    longint      ep = 0;
    longint      ef = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: constraints straight from their arithmetic definitions.
    function automatic logic [3:0] model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                         input logic [2:0] m);
        longint amod = longint'(1) << A_W;
        longint cmod = longint'(1) << CALC_W;
        longint ai   = longint'(a);
        longint bi   = longint'(b);
        longint neg  = (amod - ai) % amod;
        logic [2:0] f;
        logic x;
        f[0] = (neg / DIV) != 0;
        f[1] = (ai != 0) && (bi != 0);
        f[2] = (((bi + longint'(OFFSET)) % cmod) >> SHIFT) != 0;
        x = 1'b1;
        for (int i = 0; i < 3; i++) if (m[i] && !f[i]) x = 1'b0;
        return {f, x};
    endfunction

    // One clock: observe at negedge, score, then return 1 time unit after posedge.
    task automatic cycle();
        logic dlv;
        logic dlv_x;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        dlv      = 1'b0;
        dlv_x    = 1'b0;
        if (hold) chk("hold_valid", 32'(out_valid), 1);
        if (out_valid) begin
            chk("out_has_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("out_flags", 32'(out_flags), 32'(exp_q[0][3:1]));
                chk("out_x", 32'(out_x), 32'(exp_q[0][0]));
                if (out_ready) begin
                    dlv   = 1'b1;
                    dlv_x = exp_q[0][0];
                    void'(exp_q.pop_front());
                    n_dlv++;
                end
            end
        end
        hold = out_valid && !out_ready;
        if (last_acc) exp_q.push_back(pend_exp);
`ifdef SPLIT_CONSTRAINT_STATS_EN
        if (stats_clr) begin
            ep = 0;
            ef = 0;
        end else if (dlv) begin
            if (dlv_x) ep = (ep + 1 > (longint'(1) << CNT_W) - 1) ? ep : ep + 1;
            else       ef = (ef + 1 > (longint'(1) << CNT_W) - 1) ? ef : ef + 1;
        end
`endif
        @(posedge clk);
        #1;
`ifdef SPLIT_CONSTRAINT_STATS_EN
        chk("pass_cnt", 32'(pass_cnt), 32'(ep));
        chk("fail_cnt", 32'(fail_cnt), 32'(ef));
`endif
    endtask

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [2:0] m, input logic [3:0] e);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mask  = m;
        pend_exp = e;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        chk("send_accepted", 32'(last_acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic set_rand(input logic [2:0] m);
        in_a     = A_W'($urandom);
        in_b     = B_W'($urandom);
        in_mask  = m;
        pend_exp = model(in_a, in_b, in_mask);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int k;
        int c;
        int d0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mask   = '0;
        out_ready = 1'b0;
        pend_exp  = '0;
`ifdef SPLIT_CONSTRAINT_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_x", 32'(out_x), 0);
        chk("rst_out_flags", 32'(out_flags), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
`ifdef SPLIT_CONSTRAINT_STATS_EN
        chk("rst_pass", 32'(pass_cnt), 0);
        chk("rst_fail", 32'(fail_cnt), 0);
`endif
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed vectors with hand-derived expectations, plus latency.
        send(4'h1, 16'h0001, 3'b111, {3'b111, 1'b1});
        chk("lat_cycle1", 32'(out_valid), 0);
        cycle();
        chk("lat_cycle2", 32'(out_valid), 1);
        send(4'hC, 16'h0001, 3'b111, {3'b110, 1'b0});
        send(4'h0, 16'h0000, 3'b100, {3'b100, 1'b1});
        send(4'h0, 16'h0000, 3'b011, {3'b100, 1'b0});
        send(4'h1, 16'hF457, 3'b111, {3'b011, 1'b0});
        send(4'h3, 16'h0010, 3'b000, {3'b111, 1'b1});
        drain();

        // Backpressure: 6 candidates, output stalled for 5 cycles.
        d0        = n_dlv;
        out_ready = 1'b0;
        k         = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            set_rand(3'b111);
            cycle();
            if (last_acc) k++;
        end
        chk("bp_accepts", 32'(k), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        c = 0;
        while (k < 6 && c < 20) begin
            in_valid = 1'b1;
            set_rand(3'(c));
            cycle();
            if (last_acc) k++;
            c++;
        end
        chk("bp_full_rate", 32'(c), 4);
        drain();
        chk("bp_delivered", 32'(n_dlv - d0), 6);

        // Randomized traffic with random handshakes.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            set_rand(3'($urandom));
            cycle();
        end
        drain();

        // Reset with two candidates in flight.
        out_ready = 1'b0;
        send(4'h1, 16'h0001, 3'b111, {3'b111, 1'b1});
        send(4'h2, 16'h0002, 3'b111, model(4'h2, 16'h0002, 3'b111));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_x", 32'(out_x), 0);
        chk("midrst_out_flags", 32'(out_flags), 0);
        exp_q.delete();
        hold = 1'b0;
        ep   = 0;
        ef   = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("no_stale", 32'(out_valid), 0);
        end
        send(4'h5, 16'h0123, 3'b111, model(4'h5, 16'h0123, 3'b111));
        drain();

`ifdef SPLIT_CONSTRAINT_STATS_EN
        // Saturation and clear priority.
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(A_W'(i), B_W'(i * 7), 3'b000, model(A_W'(i), B_W'(i * 7), 3'b000));
        drain();
        chk("pass_saturated", 32'(pass_cnt), 3);
        chk("fail_zero", 32'(fail_cnt), 0);
        out_ready = 1'b0;
        send(4'h0, 16'h0000, 3'b011, {3'b100, 1'b0});
        cycle();
        chk("clr_pending_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        chk("clr_pass", 32'(pass_cnt), 0);
        chk("clr_fail", 32'(fail_cnt), 0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/split_constraint_pipe.md
Name: split_constraint_pipe

Overview:
- Streaming, parametrised successor of the single-shot split constraint checkers.
- Accepts one candidate assignment per cycle: operand A (narrow, divide constraint) and operand B (wide, add/shift constraint).
- Evaluates three constraint classes and a maskable AND over them in a 2-stage pipeline with valid/ready backpressure.
- Sits between the assignment enumerator and the BDD-solver result collector.

Parameters:
A_W, 4, width of operand A.
B_W, 12, width of operand B.
CALC_W, 16, arithmetic width for the B constraint (must be >= B_W).
DIV, 5, constant divisor for constraint C0 (non-zero).
OFFSET, 16'h0BA9, additive constant for C2, truncated/zero-extended to CALC_W.
SHIFT, 4, right-shift amount for C2 (< CALC_W).
CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  candidate valid.
in_ready  out  1  candidate accepted when in_valid && in_ready.
in_a  in  A_W  operand A.
in_b  in  B_W  operand B.
in_mask  in  3  per-candidate constraint enable, bit i enables Ci.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_x  out  1  AND of enabled constraints.
out_flags  out  3  raw C2..C0 results, unmasked.
stats_clr  in  1  synchronous clear of the counters (optional feature only).
pass_cnt  out  CNT_W  results delivered with out_x=1 (optional feature only).
fail_cnt  out  CNT_W  results delivered with out_x=0 (optional feature only).

Behaviour:
- Reset (async assert, sync deassert inside the block): s1_valid=0, s2_valid=0, out_valid=0, out_x=0, out_flags=0, counters=0.
- C0 = |(((-in_a) mod 2^A_W) / DIV), unsigned, computed in A_W bits.
- C1 = (in_a != 0) && (in_b != 0). This is a logical AND, not bitwise.
- C2 = |(((zext(in_b) + OFFSET) mod 2^CALC_W) >> SHIFT).
- Stage 1 registers C0..C2 and in_mask.
- Stage 2 registers out_flags and out_x = &(~mask | flags).
  - mask=0 gives out_x=1 (vacuous).
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 per cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
- Stage 2 loads when s1_valid && s2_adv; otherwise s2_valid clears on out_ready.
- Stage 1 loads on accept; otherwise s1_valid clears when it moves to stage 2.
- Output stability: while out_valid && !out_ready, out_x and out_flags hold stable. No data is lost or duplicated.
- Simultaneous accept and output handoff in the same cycle are legal and sustain full rate.
- Reset mid-stream discards all in-flight candidates. No partial results appear after reset.

Optional Feature:
- Macro: SPLIT_CONSTRAINT_STATS_EN.
- Defined:
  - pass_cnt and fail_cnt exist and increment on each out_valid && out_ready, according to out_x.
  - Counters saturate at all-ones and never wrap.
  - stats_clr zeroes both counters next cycle and has priority over a same-cycle increment.
- Undefined:
  - stats_clr, pass_cnt and fail_cnt ports are absent and no counter logic is built.
  - Datapath and handshake are identical to the defined case.

Test Plan:
- Defaults, mask=3'b111, out_ready=1: a=4'h1, b=12'h001 -> 2 cycles later out_flags=3'b111, out_x=1. Then a=4'hC -> flags=3'b110 (-12=4, 4/5=0), out_x=0.
- a=4'h0, b=12'h000, mask=3'b100 -> flags=3'b100 (C2: 0xBA9>>4=0xBA), out_x=1. Same input with mask=3'b011 -> out_x=0.
- B_W=16, CALC_W=16: b=16'hF457, a=4'h1 -> sum wraps to 0, flags=3'b011, out_x=0 with mask=3'b111.
- Backpressure:
  - Stream 6 candidates with out_ready held 0 for 5 cycles: in_ready drops after 2 accepts and out_valid holds stable.
  - Release out_ready: all 6 results emerge in order at 1 per cycle with no loss or duplicates.
- Reset: assert rst_n=0 with 2 candidates in flight -> out_valid=0 immediately. After release, no stale result appears.
- SPLIT_CONSTRAINT_STATS_EN, CNT_W=2:
  - 5 passing results -> pass_cnt saturates at 3.
  - stats_clr with a simultaneous delivery -> pass_cnt=0 and fail_cnt=0 next cycle.
